regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Arbitrates two writeback requesters (req0 = ALU, req1 = load unit) onto the
//  single register-file write port; registers the winning write (1-cycle latency).
//  Suppresses writes to x0 and exposes an in-flight bypass for the two read
//  ports, so decode sees data that is granted but not yet in the register file.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  DATA_W      32  width of write data
//  IDX_W       5   width of register index
//  FIXED_PRIO  0   0 = round-robin; 1 = req0 always wins
// PORTS
//  clk          in   1       clock, rising edge
//  nRST         in   1       reset, asynchronous, active-low
//  wb_en        in   1       1 = grants allowed; 0 = hold all requesters
//  req0_valid   in   1       ALU write request
//  req0_index   in   IDX_W   ALU destination register
//  req0_data    in   DATA_W  ALU write data
//  req0_ready   out  1       ALU request accepted this cycle
//  req1_valid   in   1       load write request
//  req1_index   in   IDX_W   load destination register
//  req1_data    in   DATA_W  load write data
//  req1_ready   out  1       load request accepted this cycle
//  reg_write    out  1       register-file write enable
//  write_index  out  IDX_W   register-file write index
//  write_data   out  DATA_W  register-file write data
//  rd_index1/2  in   IDX_W   register-file read indices (from decode)
//  byp_hit1/2   out  1       read index matches the in-flight write
//  byp_data1/2  out  DATA_W  in-flight write data (valid when byp_hit)
//  write_count  out  16      saturating count of committed writes
// BEHAVIOUR
//  Reset: reg_write=0, write_index=0, write_data=0, write_count=0, prio=req0.
//  Handshake: transfer when valid && ready; ready is combinational and equals
//   the grant; at most one ready per cycle; a requester holds valid/index/data
//   stable until ready. A ready is never asserted without the matching valid.
//  wb_en=0: both ready=0; the output stage still drains its current entry.
//  Grant (wb_en=1): one valid -> that requester. Both valid:
//   FIXED_PRIO=1 -> req0. FIXED_PRIO=0 -> requester named by prio; after any
//   grant, prio points to the other requester. prio does not change in idle cycles.
//  Output stage: grant in cycle N -> reg_write=1 with that index/data in N+1
//   (register-file write at edge ending N+1). No grant -> reg_write=0 in N+1;
//   write_index/write_data hold their last value.
//  x0: a request with index 0 is granted normally (ready=1) and consumes prio,
//   but produces reg_write=0 in N+1 and no write_count increment.
//  Back-to-back: a new grant every cycle is allowed; the register file never
//   back-pressures.
//  Bypass: byp_hitK = reg_write && (rd_indexK == write_index) &&
//   (write_index != 0); byp_dataK = write_data. This is combinational from the
//   output stage only; requests not yet granted are never bypassed.
//  write_count: +1 per cycle with reg_write=1; saturates at 16'hFFFF.
//  Reset mid-operation: the output stage and prio clear immediately (async);
//   the pending write is dropped. Requesters re-present after reset.
// TESTING
//  1 reset; req0 valid idx=3 data=32'hDEAD_BEEF -> req0_ready=1 same cycle;
//    next cycle reg_write=1, write_index=3, write_data=32'hDEAD_BEEF, count=1
//  2 RR: both valid for 4 cycles (idx 1 / idx 2) -> grants 0,1,0,1;
//    reg_write on 4 consecutive cycles; FIXED_PRIO=1 build -> all 4 to req0
//  3 req1 valid idx=0 data=5 -> req1_ready=1; next cycle reg_write=0,
//    count unchanged; then req0+req1 both valid -> req0 wins (prio moved to req0)
//  4 wb_en=0 with both valid -> both ready=0 for 3 cycles, reg_write=0 after
//    drain; wb_en=1 -> grants resume in RR order from prio
//  5 grant idx=7 data=9; next cycle rd_index1=7, rd_index2=8 -> byp_hit1=1,
//    byp_data1=9, byp_hit2=0; rd_index1=0 while writing x0 -> byp_hit1=0
//  6 nRST low in the cycle after a grant -> reg_write=0 immediately,
//    count=0, prio=req0; force count=16'hFFFE, commit 3 writes -> 16'hFFFF

Source files
------------

// File: rtl/regfile_wb_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_if
//   Bundles the writeback-arbiter signals: the two requester handshakes
//   (req0 = ALU, req1 = load unit), the grant enable, the registered
//   register-file write port and the decode-side read/bypass lookup.
//   master : requesters, decode and the register file (drive requests and
//            read indices, observe ready, write port and bypass)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface regfile_wb_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5
);
   logic              wb_en;
   logic              req0_valid;
   logic [IDX_W-1:0]  req0_index;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [IDX_W-1:0]  req1_index;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              reg_write;
   logic [IDX_W-1:0]  write_index;
   logic [DATA_W-1:0] write_data;
   logic [IDX_W-1:0]  rd_index1;
   logic [IDX_W-1:0]  rd_index2;
   logic              byp_hit1;
   logic              byp_hit2;
   logic [DATA_W-1:0] byp_data1;
   logic [DATA_W-1:0] byp_data2;

   modport master (
      output wb_en,
      output req0_valid, req0_index, req0_data, input req0_ready,
      output req1_valid, req1_index, req1_data, input req1_ready,
      input  reg_write, write_index, write_data,
      output rd_index1, rd_index2,
      input  byp_hit1, byp_hit2, byp_data1, byp_data2
   );

   modport slave (
      input  wb_en,
      input  req0_valid, req0_index, req0_data, output req0_ready,
      input  req1_valid, req1_index, req1_data, output req1_ready,
      output reg_write, write_index, write_data,
      input  rd_index1, rd_index2,
      output byp_hit1, byp_hit2, byp_data1, byp_data2
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Arbitrates the ALU (req0) and load unit (req1) onto the single
//   register-file write port. The winning write is registered (1-cycle
//   latency), writes to x0 are suppressed, and the registered write is
//   exposed to decode as a bypass for both read ports.
// Ports
//   clk          clock, rising edge
//   nRST         asynchronous active-low reset
//   bus          regfile_wb_if.slave: handshakes, write port, read/bypass
//   write_count  saturating count of committed register-file writes
// Parameters
//   DATA_W, IDX_W  data / register-index widths (must match the interface)
//   FIXED_PRIO     0 = round-robin, 1 = req0 always wins
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int IDX_W      = 5,
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        nRST,
   regfile_wb_if.slave bus,
   output logic [15:0] write_count
);

   typedef enum logic {
      PRIO_REQ0 = 1'b0,
      PRIO_REQ1 = 1'b1
   } prio_t;

   prio_t             prio, prio_next;
   logic              grant0, grant1, grant_any;
   logic [IDX_W-1:0]  grant_index;
   logic [DATA_W-1:0] grant_data;
   logic              commit;

   logic              wr_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] data_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of process ordering.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) prio <= PRIO_REQ0;
      else       prio <= prio_next;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      grant0    = 1'b0;
      grant1    = 1'b0;
      prio_next = prio;
      if (bus.wb_en) begin
         if (bus.req0_valid && bus.req1_valid) begin
            if (FIXED_PRIO != 0 || prio == PRIO_REQ0) grant0 = 1'b1;
            else                                      grant1 = 1'b1;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
      // Priority only moves on a grant; idle cycles leave it alone.
      if (grant0)      prio_next = PRIO_REQ1;
      else if (grant1) prio_next = PRIO_REQ0;
   end

   assign grant_any   = grant0 | grant1;
   assign grant_index = grant0 ? bus.req0_index : bus.req1_index;
   assign grant_data  = grant0 ? bus.req0_data  : bus.req1_data;
   // A grant to x0 completes the handshake but never reaches the register file.
   assign commit      = grant_any && (grant_index != '0);

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   // NOTE: the whole output stage is reset, so a write in flight when nRST
   // falls is dropped immediately rather than committed after reset.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         wr_q        <= 1'b0;
         idx_q       <= '0;
         data_q      <= '0;
         write_count <= '0;
      end else begin
         wr_q <= commit;
         // Index/data hold between grants; an x0 grant loads them but with
         // wr_q low, so neither the write port nor the bypass acts on them.
         if (grant_any) begin
            idx_q  <= grant_index;
            data_q <= grant_data;
         end
         // Counted on the same edge that raises reg_write, so the count
         // already includes the write currently presented to the file.
         if (commit && write_count != 16'hFFFF)
            write_count <= write_count + 16'd1;
      end
   end

   assign bus.reg_write   = wr_q;
   assign bus.write_index = idx_q;
   assign bus.write_data  = data_q;

   // Bypass looks only at the output stage; ungranted requests are invisible.
   assign bus.byp_hit1  = wr_q && (bus.rd_index1 == idx_q) && (idx_q != '0);
   assign bus.byp_hit2  = wr_q && (bus.rd_index2 == idx_q) && (idx_q != '0);
   assign bus.byp_data1 = data_q;
   assign bus.byp_data2 = data_q;

endmodule
